// File: rtl/ntt_piso_ctrl_pkg.sv
// ntt_piso_ctrl_pkg
// Shared constants for the NTT PISO FIFO sequencer: coefficient and line geometry,
// the default polynomial length and the sequencer state encodings.
// No ports.

package ntt_piso_ctrl_pkg;

    localparam int unsigned CoefW       = 24;
    localparam int unsigned CoefPerLine = 4;
    localparam int unsigned LineW       = CoefW * CoefPerLine;
    localparam int unsigned NLinesDef   = 64;

    typedef logic [LineW-1:0] line_t;

    // Sequencer states, kept as plain constants for legacy tool flows.
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

endpackage

// File: rtl/ntt_piso_vld_track.sv
// ntt_piso_vld_track
// Valid shadow of the PISO FIFO. It is a DEPTH-entry bit shift register plus an output
// bit that moves under exactly the same ce/load rules as the data FIFO, so the output
// bit says whether the FIFO's data_out holds a live coefficient. Unlike the FIFO it is
// reset, which keeps stale FIFO contents from ever being flagged valid.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   ce_i     FIFO clock enable
//   load_i   FIFO parallel load (entries 0..3)
//   valid_o  data_out of the FIFO is live

module ntt_piso_vld_track #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ce_i,
    input  logic load_i,
    output logic valid_o
);

    logic [DEPTH-1:0] sr_q, sr_d;
    logic             out_q, out_d;

    always_comb begin
        sr_d  = sr_q;
        out_d = out_q;
        if (ce_i) begin
            out_d = sr_q[DEPTH-1];
            for (int i = 1; i < int'(DEPTH); i++) begin
                sr_d[i] = sr_q[i-1];
            end
            sr_d[0] = 1'b0;
            // A load overwrites the four lowest entries; higher entries still shift.
            if (load_i) begin
                sr_d[3:0] = 4'b1111;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q  <= '0;
            out_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            out_q <= out_d;
        end
    end

    assign valid_o = out_q;

endmodule

// File: rtl/ntt_piso_ctrl.sv
// ntt_piso_ctrl
// Sequencer for the NTT parallel-in/serial-out coefficient FIFO. Fetches 4-coefficient
// lines from the coefficient RAM, keeps one line ahead in a buffer, drives the FIFO's
// ce/load/line inputs and presents the FIFO's serial output as a valid/ready stream.
// One start streams one whole polynomial (NLINES*4 coefficients).
// Build option: define NTT_PISO_CTRL_BITREV_EN to fetch lines in bit-reversed address
// order; streaming timing is the same either way.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                one-cycle pulse, begin a polynomial (ignored while busy)
//   busy_o, done_o         busy from accepted start; done one cycle after last handshake
//   mem_ren_o, mem_raddr_o RAM read port request (data returns the following cycle)
//   mem_rdata_i            RAM line data
//   piso_ce_o, piso_load_o FIFO enable / parallel load
//   piso_line_o            FIFO line input, from the line buffer
//   out_valid_o/out_ready_i/out_last_o  output stream qualifiers

module ntt_piso_ctrl
    import ntt_piso_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NLINES = NLinesDef,
    parameter int unsigned AW     = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             mem_ren_o,
    output logic [AW-1:0]    mem_raddr_o,
    input  logic [LineW-1:0] mem_rdata_i,
    output logic             piso_ce_o,
    output logic             piso_load_o,
    output logic [LineW-1:0] piso_line_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o
);

    localparam int unsigned     LW       = $clog2(NLINES);
    localparam logic [AW:0]     NLinesC  = (AW+1)'(NLINES);
    localparam logic [AW:0]     LastLine = (AW+1)'(NLINES - 1);
    localparam logic [AW+1:0]   LastCoef = (AW+2)'(NLINES * CoefPerLine - 1);

    logic [1:0]    state_q, state_d;
    logic [AW:0]   rd_cnt_q, rd_cnt_d;
    logic [AW:0]   ld_cnt_q, ld_cnt_d;
    logic [AW+1:0] out_cnt_q, out_cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic          rd_pend_q, rd_pend_d;
    line_t         buf_q, buf_d;
    logic          buf_vld_q, buf_vld_d;
    logic          done_q, done_d;

    logic busy, run, drain, stall, ce, load, ren, hs, last;

    assign busy  = (state_q != StIdle);
    assign run   = (state_q == StRun);
    assign drain = (state_q == StDrain);
    // Only a live coefficient that downstream refuses can hold the FIFO; bubbles never do.
    assign stall = out_valid_o & ~out_ready_i;
    // At phase 0 the FIFO must load, so without a buffered line it is simply not clocked.
    assign ce    = ~stall & (run ? ((phase_q != 2'd0) | buf_vld_q) : drain);
    assign load  = ce & (phase_q == 2'd0) & buf_vld_q & run;
    assign ren   = busy & ~buf_vld_q & ~rd_pend_q & (rd_cnt_q < NLinesC);
    assign hs    = out_valid_o & out_ready_i;
    assign last  = out_valid_o & (out_cnt_q == LastCoef);

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        ld_cnt_d  = ld_cnt_q;
        out_cnt_d = out_cnt_q;
        phase_d   = phase_q;
        rd_pend_d = ren;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        done_d    = 1'b0;

        // A pending read implies an empty buffer, so capture and load never coincide.
        if (rd_pend_q) begin
            buf_d     = mem_rdata_i;
            buf_vld_d = 1'b1;
        end
        if (load) begin
            buf_vld_d = 1'b0;
            ld_cnt_d  = ld_cnt_q + 1'b1;
        end
        if (ren) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (ce) begin
            phase_d = phase_q + 2'd1;
        end
        if (hs) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StRun;
                    rd_cnt_d  = '0;
                    ld_cnt_d  = '0;
                    out_cnt_d = '0;
                    phase_d   = 2'd0;
                    rd_pend_d = 1'b0;
                    buf_vld_d = 1'b0;
                end
            end
            StRun: begin
                if (load && (ld_cnt_q == LastLine)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (hs && last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            rd_cnt_q  <= '0;
            ld_cnt_q  <= '0;
            out_cnt_q <= '0;
            phase_q   <= 2'd0;
            rd_pend_q <= 1'b0;
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            ld_cnt_q  <= ld_cnt_d;
            out_cnt_q <= out_cnt_d;
            phase_q   <= phase_d;
            rd_pend_q <= rd_pend_d;
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        mem_raddr_o = '0;
`ifdef NTT_PISO_CTRL_BITREV_EN
        for (int i = 0; i < int'(LW); i++) begin
            mem_raddr_o[i] = rd_cnt_q[int'(LW) - 1 - i];
        end
`else
        mem_raddr_o = rd_cnt_q[AW-1:0];
`endif
    end

    ntt_piso_vld_track #(
        .DEPTH (DEPTH)
    ) u_vld_track (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .ce_i    (ce),
        .load_i  (load),
        .valid_o (out_valid_o)
    );

    assign busy_o      = busy;
    assign done_o      = done_q;
    assign mem_ren_o   = ren;
    assign piso_ce_o   = ce;
    assign piso_load_o = load;
    assign piso_line_o = buf_q;
    assign out_last_o  = last;

endmodule
